branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor that replaces static predict-not-taken in the pipelined RV32I core.
//  IF stage looks up the fetch PC and gets a taken/target prediction in the same cycle.
//  MEM stage reports resolved control transfers; the block trains its tables and flags mispredicts.
//  It drives the redirect PC that flushes IF/ID, ID/EX and EX/MEM.
//  Mode-selectable: bimodal or gshare (GHR XOR PC index).
// PARAMETERS
//  XLEN         32   address/data width
//  BHT_ENTRIES  256  2-bit counter table depth, power of 2
//  BTB_ENTRIES  64   direct-mapped target buffer depth, power of 2
//  GHR_W        8    global history bits, <= log2(BHT_ENTRIES)
//  GSHARE       1    1: idx = pc[..2]^GHR; 0: idx = pc[..2] (bimodal)
// PORTS
//  clk             in   1     core clock
//  rst             in   1     synchronous active-high reset
//  stall           in   1     pipeline stall (cache miss / load-use); freezes training
//  if_pc           in   XLEN  fetch PC
//  pred_taken      out  1     predict taken for if_pc
//  pred_target     out  XLEN  predicted next PC (if_pc+4 when not taken)
//  upd_valid       in   1     MEM-stage instruction is a branch/JAL/JALR
//  upd_is_cond     in   1     1 = conditional branch, 0 = unconditional jump
//  upd_pc          in   XLEN  PC of resolving instruction
//  upd_taken       in   1     resolved direction
//  upd_target      in   XLEN  resolved target (ALU result)
//  upd_pred_taken  in   1     prediction carried down the pipe with the instruction
//  upd_pred_target in   XLEN  predicted next PC carried down the pipe
//  mispredict      out  1     flush request, combinational from upd_* inputs
//  redirect_pc     out  XLEN  correct next PC when mispredict=1
//  perf_branches   out  32    resolved control transfers counted
//  perf_mispred    out  32    mispredicts counted
// BEHAVIOUR
//  Reset (rst=1 at posedge): all BHT counters = 2'b01 (weak not-taken); all BTB valid = 0;
//   GHR = 0; perf counters = 0. Outputs after reset: pred_taken=0, pred_target=if_pc+4.
//  Lookup is combinational, zero latency: bidx from if_pc[log2(BHT)+1:2] (XOR GHR if GSHARE).
//   BTB index = if_pc[log2(BTB)+1:2]; tag = if_pc[XLEN-1:log2(BTB)+2].
//   pred_taken = btb_hit & (btb_uncond | bht[bidx][1]). pred_target = btb target on taken, else if_pc+4.
//  Resolution is combinational; only when upd_valid & !stall:
//   actual_next = upd_taken ? upd_target : upd_pc+4.
//   mispredict  = (upd_taken != upd_pred_taken) | (actual_next != upd_pred_target).
//   redirect_pc = actual_next. When upd_valid=0 or stall=1: mispredict=0 and redirect_pc=upd_pc+4.
//  Training happens at posedge with the same qualification (upd_valid & !stall):
//   BHT: conditional only; saturating +1 when taken, -1 when not taken; 11 and 00 stick.
//    Index uses the GHR value held before this update.
//   GHR: conditional only; GHR <= {GHR[GHR_W-2:0], upd_taken}. Non-speculative, so no repair is needed.
//   BTB: on upd_taken, write {valid=1, tag, target, uncond=!upd_is_cond}.
//    A not-taken branch never allocates an entry and leaves any existing entry in place.
//   perf_branches +1. perf_mispred +1 when mispredict. Both saturate at 32'hFFFF_FFFF.
//  Simultaneous lookup and update to the same entry: lookup returns the pre-update value (no bypass).
//  Stall held for N cycles: no state changes, so the stalled MEM instruction trains exactly once.
//  Reset mid-operation clears all state regardless of upd_valid.
//  Unaligned targets are stored verbatim; the predictor does not check them.
// STRUCTURE
//  rv32i_types gains typedef btb_entry_t {valid, uncond, tag, target}.
//  The same package holds localparams for the counter encodings: SNT=00, WNT=01, WT=10, ST=11.
//  Sub-module sat_counter2 provides a 2-bit saturating update function/module used by the BHT.
//  BHT and BTB are flop arrays (no SRAM macro) so lookup reads combinationally.
//  The pipeline registers carry pred_taken/pred_target, added to rv32i_control_word.
// TESTING
//  1. Reset, then if_pc=0x60 -> pred_taken=0, pred_target=0x64; perf counters=0.
//  2. Bimodal, branch at 0x80 to 0x40 resolved taken 2x with pred 0 each time:
//     mispredict=1 both times, redirect_pc=0x40. Then lookup 0x80 -> pred_taken=1, target=0x40.
//  3. Saturation: 4 taken then 1 not-taken at 0x80 -> counter 11->10; lookup still predicts taken.
//     A second not-taken gives 01 -> pred_taken=0.
//  4. JAL at 0x100 to 0x200, taken once -> lookup 0x100 gives pred_taken=1, target=0x200
//     independent of the BHT. Aliasing PC 0x100+4*BTB_ENTRIES -> tag miss, pred_taken=0.
//  5. stall=1 for 3 cycles with upd_valid=1 mispredicting -> mispredict=0, no counter change.
//     After stall drops, one update and perf_mispred +1 exactly.
//  6. GSHARE: alternating T/NT branch at 0x80 for 40 iterations ->
//     perf_mispred growth < 4 over the last 20 resolutions. Also check rst mid-sequence clears GHR/BTB.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and encodings for the branch predictor
// Purpose: 2-bit counter encodings and the BTB entry layout used by the predictor.
// Ports: none (package).
package branch_predictor_pkg;

  localparam int BP_XLEN = 32;

  // 2-bit direction counter encodings
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // The tag field is kept at full width; bits above the real tag width stay zero.
  typedef struct packed {
    logic               valid;
    logic               uncond;
    logic [BP_XLEN-1:0] tag;
    logic [BP_XLEN-1:0] target;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating counter next-state logic
// Purpose: computes the trained value of one BHT counter.
// Ports:
//   cnt      in  2  current counter value
//   inc      in  1  1 = count up (taken), 0 = count down (not taken)
//   cnt_next out 2  saturated next value (11 and 00 stick)
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (inc) begin
      if (cnt != ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal/gshare branch predictor with BTB
// Purpose: zero-latency IF-stage prediction, MEM-stage resolution/training and
//   mispredict redirect for the pipelined RV32I core.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    freezes training and suppresses mispredict
//   if_pc                    fetch PC looked up combinationally
//   pred_taken, pred_target  prediction for if_pc (target = if_pc+4 when not taken)
//   upd_valid, upd_is_cond   MEM-stage control transfer present / is conditional
//   upd_pc, upd_taken, upd_target           resolved outcome
//   upd_pred_taken, upd_pred_target         prediction carried down the pipe
//   mispredict, redirect_pc  flush request and correct next PC
//   perf_branches, perf_mispred             saturating event counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN        = BP_XLEN,
  parameter int BHT_ENTRIES = 256,
  parameter int BTB_ENTRIES = 64,
  parameter int GHR_W       = 8,
  parameter int GSHARE      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic            upd_is_cond,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     perf_branches,
  output logic [31:0]     perf_mispred
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
  localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_SHIFT = BTB_IDX_W + 2;

  // Flop arrays so both the lookup and the update port read combinationally.
  logic [1:0]       bht [BHT_ENTRIES];
  btb_entry_t       btb [BTB_ENTRIES];
  logic [GHR_W-1:0] ghr;

  function automatic logic [BHT_IDX_W-1:0] bht_index(input logic [XLEN-1:0] pc,
                                                     input logic [GHR_W-1:0] hist);
    bht_index = pc[BHT_IDX_W+1:2];
    if (GSHARE != 0) bht_index = bht_index ^ BHT_IDX_W'(hist);
  endfunction

  // ---------------- lookup ----------------
  logic [BHT_IDX_W-1:0] if_bidx;
  logic [BTB_IDX_W-1:0] if_eidx;
  btb_entry_t           if_entry;
  logic                 if_hit;

  assign if_bidx     = bht_index(if_pc, ghr);
  assign if_eidx     = if_pc[BTB_IDX_W+1:2];
  assign if_entry    = btb[if_eidx];
  assign if_hit      = if_entry.valid && (if_entry.tag == (if_pc >> TAG_SHIFT));
  // Jumps always redirect on a hit; branches need the counter's MSB.
  assign pred_taken  = if_hit & (if_entry.uncond | bht[if_bidx][1]);
  assign pred_target = pred_taken ? if_entry.target : if_pc + XLEN'(4);

  // ---------------- resolution ----------------
  logic                 upd_en;
  logic [XLEN-1:0]      upd_seq;
  logic [XLEN-1:0]      actual_next;
  logic [BHT_IDX_W-1:0] upd_bidx;
  logic [BTB_IDX_W-1:0] upd_eidx;
  logic [1:0]           ctr_next;

  assign upd_en      = upd_valid & ~stall;
  assign upd_seq     = upd_pc + XLEN'(4);
  assign actual_next = upd_taken ? upd_target : upd_seq;
  assign mispredict  = upd_en & ((upd_taken != upd_pred_taken) |
                                 (actual_next != upd_pred_target));
  assign redirect_pc = upd_en ? actual_next : upd_seq;

  // Training uses the history held before this update.
  assign upd_bidx = bht_index(upd_pc, ghr);
  assign upd_eidx = upd_pc[BTB_IDX_W+1:2];

  branch_predictor_sat_counter2 u_sat (
    .cnt      (bht[upd_bidx]),
    .inc      (upd_taken),
    .cnt_next (ctr_next)
  );

  // ---------------- training ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '0;
      ghr           <= '0;
      perf_branches <= '0;
      perf_mispred  <= '0;
    end else if (upd_en) begin
      if (upd_is_cond) begin
        bht[upd_bidx] <= ctr_next;
        ghr           <= (ghr << 1) | GHR_W'(upd_taken);
      end
      // Not-taken outcomes never allocate or evict.
      if (upd_taken) begin
        btb[upd_eidx] <= '{valid:  1'b1,
                           uncond: ~upd_is_cond,
                           tag:    upd_pc >> TAG_SHIFT,
                           target: upd_target};
      end
      if (perf_branches != '1) perf_branches <= perf_branches + 32'd1;
      if (mispredict && (perf_mispred != '1)) perf_mispred <= perf_mispred + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor (bimodal and gshare)
module tb_branch_predictor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall;
  logic [31:0] if_pc;
  logic        upd_valid, upd_is_cond, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;

  logic        b_pred_taken, b_mispredict, g_pred_taken, g_mispredict;
  logic [31:0] b_pred_target, b_redirect_pc, b_perf_branches, b_perf_mispred;
  logic [31:0] g_pred_target, g_redirect_pc, g_perf_branches, g_perf_mispred;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.GSHARE(0)) u_bim (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
    .pred_taken(b_pred_taken), .pred_target(b_pred_target),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(b_mispredict), .redirect_pc(b_redirect_pc),
    .perf_branches(b_perf_branches), .perf_mispred(b_perf_mispred)
  );

  branch_predictor #(.GSHARE(1)) u_gsh (
    .clk(clk), .rst(rst), .stall(stall), .if_pc(if_pc),
    .pred_taken(g_pred_taken), .pred_target(g_pred_target),
    .upd_valid(upd_valid), .upd_is_cond(upd_is_cond), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .mispredict(g_mispredict), .redirect_pc(g_redirect_pc),
    .perf_branches(g_perf_branches), .perf_mispred(g_perf_mispred)
  );

  // ---------------- reference model (mode 0 = bimodal, 1 = gshare) ----------------
  int          m_bht [2][256];
  int unsigned m_ghr [2];
  bit          m_bv  [64];
  bit          m_bu  [64];
  logic [31:0] m_btag[64];
  logic [31:0] m_btgt[64];
  int unsigned m_pb, m_pm;

  function automatic int m_idx(int m, logic [31:0] pc);
    int i;
    i = int'((pc / 4) % 256);
    if (m == 1) i = i ^ int'(m_ghr[1]);
    return i;
  endfunction

  function automatic bit m_ptaken(int m, logic [31:0] pc);
    int e;
    e = int'((pc / 4) % 64);
    return m_bv[e] && (m_btag[e] == pc / 256) && (m_bu[e] || m_bht[m][m_idx(m, pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(int m, logic [31:0] pc);
    return m_ptaken(m, pc) ? m_btgt[int'((pc / 4) % 64)] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] m_actual();
    return upd_taken ? upd_target : upd_pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    return upd_valid && !stall &&
           ((upd_taken != upd_pred_taken) || (m_actual() != upd_pred_target));
  endfunction

  function automatic logic [31:0] m_redirect();
    return (upd_valid && !stall) ? m_actual() : upd_pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 256; i++) m_bht[m][i] = 1;
      m_ghr[m] = 0;
    end
    for (int i = 0; i < 64; i++) begin
      m_bv[i] = 0; m_bu[i] = 0; m_btag[i] = 0; m_btgt[i] = 0;
    end
    m_pb = 0; m_pm = 0;
  endtask

  task automatic model_clock();
    int  idx, e;
    bit  mis;
    if (rst) begin
      model_reset();
    end else if (upd_valid && !stall) begin
      mis = m_mis();
      for (int m = 0; m < 2; m++) begin
        if (upd_is_cond) begin
          idx = m_idx(m, upd_pc);
          if (upd_taken) m_bht[m][idx] = (m_bht[m][idx] < 3) ? m_bht[m][idx] + 1 : 3;
          else           m_bht[m][idx] = (m_bht[m][idx] > 0) ? m_bht[m][idx] - 1 : 0;
          m_ghr[m] = (m_ghr[m] * 2 + (upd_taken ? 1 : 0)) % 256;
        end
      end
      if (upd_taken) begin
        e = int'((upd_pc / 4) % 64);
        m_bv[e] = 1; m_bu[e] = !upd_is_cond; m_btag[e] = upd_pc / 256; m_btgt[e] = upd_target;
      end
      m_pb++;
      if (mis) m_pm++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle_upd();
    upd_valid = 0; upd_is_cond = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_pred_taken = 0; upd_pred_target = 32'h4;
  endtask

  task automatic set_upd(bit cond, logic [31:0] pc, bit t, logic [31:0] tgt,
                         bit pt, logic [31:0] ptgt);
    upd_valid = 1; upd_is_cond = cond; upd_pc = pc; upd_taken = t;
    upd_target = tgt; upd_pred_taken = pt; upd_pred_target = ptgt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; stall = 0; idle_upd(); if_pc = 32'h60;
    step();
    rst = 0; #1;
    checks++; if (b_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_b_taken: got %0b want 0", b_pred_taken); end
    checks++; if (b_pred_target !== 32'h64) begin errors++; $display("FAIL reset_b_target: got %h want 00000064", b_pred_target); end
    checks++; if (g_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_g_taken: got %0b want 0", g_pred_taken); end
    checks++; if (g_pred_target !== 32'h64) begin errors++; $display("FAIL reset_g_target: got %h want 00000064", g_pred_target); end
    checks++; if (b_perf_branches !== 32'd0 || b_perf_mispred !== 32'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", b_perf_branches, b_perf_mispred); end
    checks++; if (b_mispredict !== 1'b0 || b_redirect_pc !== 32'h4) begin errors++; $display("FAIL reset_idle_resolve: got %0b/%h want 0/00000004", b_mispredict, b_redirect_pc); end
  endtask

  task automatic test_bimodal_train();
    if_pc = 32'h80;
    for (int k = 0; k < 2; k++) begin
      set_upd(1, 32'h80, 1, 32'h40, 0, 32'h84); #1;
      checks++; if (b_mispredict !== 1'b1) begin errors++; $display("FAIL train_mispredict[%0d]: got %0b want 1", k, b_mispredict); end
      checks++; if (b_redirect_pc !== 32'h40) begin errors++; $display("FAIL train_redirect[%0d]: got %h want 00000040", k, b_redirect_pc); end
      step();
    end
    idle_upd(); #1;
    checks++; if (b_pred_taken !== 1'b1 || b_pred_target !== 32'h40) begin errors++; $display("FAIL train_lookup: got %0b/%h want 1/00000040", b_pred_taken, b_pred_target); end
    checks++; if (g_pred_taken !== m_ptaken(1, if_pc) || g_pred_target !== m_ptarget(1, if_pc)) begin errors++; $display("FAIL train_gshare_lookup: got %0b/%h want %0b/%h", g_pred_taken, g_pred_target, m_ptaken(1, if_pc), m_ptarget(1, if_pc)); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 4; k++) begin set_upd(1, 32'h80, 1, 32'h40, 1, 32'h40); step(); end
    set_upd(1, 32'h80, 0, 32'h40, 1, 32'h40); step();
    idle_upd(); if_pc = 32'h80; #1;
    checks++; if (b_pred_taken !== 1'b1 || b_pred_target !== 32'h40) begin errors++; $display("FAIL sat_one_nt: got %0b/%h want 1/00000040", b_pred_taken, b_pred_target); end
    set_upd(1, 32'h80, 0, 32'h40, 1, 32'h40); step();
    idle_upd(); #1;
    checks++; if (b_pred_taken !== 1'b0 || b_pred_target !== 32'h84) begin errors++; $display("FAIL sat_two_nt: got %0b/%h want 0/00000084", b_pred_taken, b_pred_target); end
  endtask

  task automatic test_jal();
    set_upd(0, 32'h100, 1, 32'h200, 0, 32'h104); step();
    idle_upd(); if_pc = 32'h100; #1;
    checks++; if (b_pred_taken !== 1'b1 || b_pred_target !== 32'h200) begin errors++; $display("FAIL jal_b: got %0b/%h want 1/00000200", b_pred_taken, b_pred_target); end
    checks++; if (g_pred_taken !== 1'b1 || g_pred_target !== 32'h200) begin errors++; $display("FAIL jal_g: got %0b/%h want 1/00000200", g_pred_taken, g_pred_target); end
    if_pc = 32'h200; #1;
    checks++; if (b_pred_taken !== 1'b0 || b_pred_target !== 32'h204) begin errors++; $display("FAIL jal_alias: got %0b/%h want 0/00000204", b_pred_taken, b_pred_target); end
  endtask

  task automatic test_stall();
    int unsigned pb0, pm0;
    pb0 = m_pb; pm0 = m_pm;
    stall = 1; if_pc = 32'h80;
    set_upd(1, 32'h80, 1, 32'h40, 0, 32'h84);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (b_mispredict !== 1'b0 || b_redirect_pc !== 32'h84) begin errors++; $display("FAIL stall_resolve[%0d]: got %0b/%h want 0/00000084", k, b_mispredict, b_redirect_pc); end
      step();
    end
    #1;
    checks++; if (b_perf_branches !== pb0 || b_perf_mispred !== pm0) begin errors++; $display("FAIL stall_perf_frozen: got %0d/%0d want %0d/%0d", b_perf_branches, b_perf_mispred, pb0, pm0); end
    checks++; if (b_pred_taken !== 1'b0) begin errors++; $display("FAIL stall_bht_frozen: got %0b want 0", b_pred_taken); end
    stall = 0; #1;
    checks++; if (b_mispredict !== 1'b1) begin errors++; $display("FAIL stall_release_mis: got %0b want 1", b_mispredict); end
    step();
    idle_upd(); #1;
    checks++; if (b_perf_mispred !== pm0 + 1 || b_perf_branches !== pb0 + 1) begin errors++; $display("FAIL stall_release_perf: got %0d/%0d want %0d/%0d", b_perf_branches, b_perf_mispred, pb0 + 1, pm0 + 1); end
    checks++; if (b_pred_taken !== 1'b1 || b_pred_target !== 32'h40) begin errors++; $display("FAIL stall_release_train: got %0b/%h want 1/00000040", b_pred_taken, b_pred_target); end
  endtask

  task automatic test_gshare();
    logic [31:0] pm20;
    bit t;
    rst = 1; idle_upd(); step(); rst = 0;
    pm20 = 0;
    for (int it = 0; it < 40; it++) begin
      t = (it % 2 == 0);
      if_pc = 32'h80; #1;
      checks++; if (g_pred_taken !== m_ptaken(1, 32'h80) || g_pred_target !== m_ptarget(1, 32'h80)) begin errors++; $display("FAIL gshare_pred[%0d]: got %0b/%h want %0b/%h", it, g_pred_taken, g_pred_target, m_ptaken(1, 32'h80), m_ptarget(1, 32'h80)); end
      set_upd(1, 32'h80, t, 32'h40, g_pred_taken, g_pred_target); #1;
      checks++; if (g_mispredict !== m_mis()) begin errors++; $display("FAIL gshare_mis[%0d]: got %0b want %0b", it, g_mispredict, m_mis()); end
      if (it == 20) pm20 = g_perf_mispred;
      step();
    end
    idle_upd(); #1;
    checks++; if (g_perf_mispred !== m_pm) begin errors++; $display("FAIL gshare_perf: got %0d want %0d", g_perf_mispred, m_pm); end
    checks++; if (g_perf_mispred - pm20 >= 4) begin errors++; $display("FAIL gshare_learn: got growth %0d want <4", g_perf_mispred - pm20); end
    set_upd(1, 32'h80, 1, 32'h40, 0, 32'h84); rst = 1; step(); rst = 0;
    idle_upd(); if_pc = 32'h80; #1;
    checks++; if (g_pred_taken !== 1'b0 || g_pred_target !== 32'h84) begin errors++; $display("FAIL midrst_btb: got %0b/%h want 0/00000084", g_pred_taken, g_pred_target); end
    checks++; if (g_perf_branches !== 32'd0 || g_perf_mispred !== 32'd0) begin errors++; $display("FAIL midrst_perf: got %0d/%0d want 0/0", g_perf_branches, g_perf_mispred); end
  endtask

  task automatic test_back_to_back();
    if_pc = 32'h180;
    set_upd(0, 32'h180, 1, 32'h300, 0, 32'h184); #1;
    checks++; if (b_pred_taken !== 1'b0 || b_pred_target !== 32'h184) begin errors++; $display("FAIL b2b_no_bypass: got %0b/%h want 0/00000184", b_pred_taken, b_pred_target); end
    step();
    idle_upd(); #1;
    checks++; if (b_pred_taken !== 1'b1 || b_pred_target !== 32'h300) begin errors++; $display("FAIL b2b_after: got %0b/%h want 1/00000300", b_pred_taken, b_pred_target); end
  endtask

  task automatic test_random();
    logic [31:0] pcs [8];
    logic [31:0] tgts[4];
    int nerr;
    pcs  = '{32'h80, 32'h84, 32'h100, 32'h180, 32'h200, 32'h280, 32'h1080, 32'h2084};
    tgts = '{32'h40, 32'h300, 32'h1002, 32'h8000};
    nerr = 0;
    for (int c = 0; c < 600; c++) begin
      rst         = ($urandom % 80 == 0);
      stall       = ($urandom % 5 == 0);
      if_pc       = pcs[$urandom % 8];
      upd_valid   = ($urandom % 4 != 0);
      upd_is_cond = ($urandom % 4 != 0);
      upd_pc      = pcs[$urandom % 8];
      upd_taken   = $urandom % 2;
      upd_target  = tgts[$urandom % 4];
      if ($urandom % 2 == 0) begin
        upd_pred_taken = m_ptaken(1, upd_pc); upd_pred_target = m_ptarget(1, upd_pc);
      end else begin
        upd_pred_taken = $urandom % 2; upd_pred_target = tgts[$urandom % 4];
      end
      #1;
      checks++; if (b_pred_taken !== m_ptaken(0, if_pc) || b_pred_target !== m_ptarget(0, if_pc)) begin errors++; nerr++; if (nerr < 10) $display("FAIL rnd_b_pred[%0d]: got %0b/%h want %0b/%h", c, b_pred_taken, b_pred_target, m_ptaken(0, if_pc), m_ptarget(0, if_pc)); end
      checks++; if (g_pred_taken !== m_ptaken(1, if_pc) || g_pred_target !== m_ptarget(1, if_pc)) begin errors++; nerr++; if (nerr < 10) $display("FAIL rnd_g_pred[%0d]: got %0b/%h want %0b/%h", c, g_pred_taken, g_pred_target, m_ptaken(1, if_pc), m_ptarget(1, if_pc)); end
      checks++; if (g_mispredict !== m_mis() || g_redirect_pc !== m_redirect() || b_mispredict !== m_mis()) begin errors++; nerr++; if (nerr < 10) $display("FAIL rnd_resolve[%0d]: got %0b/%h want %0b/%h", c, g_mispredict, g_redirect_pc, m_mis(), m_redirect()); end
      step();
    end
    rst = 0; stall = 0; idle_upd(); #1;
    checks++; if (b_perf_branches !== m_pb || b_perf_mispred !== m_pm) begin errors++; $display("FAIL rnd_perf_b: got %0d/%0d want %0d/%0d", b_perf_branches, b_perf_mispred, m_pb, m_pm); end
    checks++; if (g_perf_branches !== m_pb || g_perf_mispred !== m_pm) begin errors++; $display("FAIL rnd_perf_g: got %0d/%0d want %0d/%0d", g_perf_branches, g_perf_mispred, m_pb, m_pm); end
  endtask

  initial begin
    rst = 1; stall = 0; if_pc = 0; idle_upd();
    model_reset();
    @(negedge clk);
    test_reset();
    test_bimodal_train();
    test_saturation();
    test_jal();
    test_stall();
    test_gshare();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
